bus_decode: RTL and testbench

CPU-side bus responder for the Missile Command core. Decodes the 6502 address/write-strobe bus produced by the microprocessor circuit into chip selects and write commits. Returns the interrupt-acknowledge pulse (s_INTACK_n) that clears the pending IRQ. Also owns the output latch, the 8-entry colour RAM and the frame-based watchdog that resets the CPU.

---
 rtl/mc_pkg.sv | 25 ++
 rtl/bus_decode_if.sv | 13 +
 rtl/mc_watchdog.sv | 70 +++++++
 rtl/bus_decode.sv | 99 +++++++++
 tb/tb_bus_decode.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared address map, range bounds and watchdog state type for the
// Missile Command CPU-side bus logic.
package mc_pkg;

  localparam logic [7:0] PG_OUTLATCH = 8'h48;
  localparam logic [7:0] PG_IN0      = 8'h48;
  localparam logic [7:0] PG_IN1      = 8'h49;
  localparam logic [7:0] PG_DIP      = 8'h4A;
  localparam logic [7:0] PG_COLOUR   = 8'h4B;
  localparam logic [7:0] PG_WDOG     = 8'h4C;
  localparam logic [7:0] PG_INTACK   = 8'h4D;

  // RAM starts at page 0x00 and ROM runs to 0xFF, so only the inner bounds matter.
  localparam logic [7:0] RAM_HI   = 8'h3F;
  localparam logic [7:0] POKEY_LO = 8'h40;
  localparam logic [7:0] POKEY_HI = 8'h47;
  localparam logic [7:0] ROM_LO   = 8'h50;

  typedef enum logic [1:0] {
    WD_COUNT,
    WD_FIRE,
    WD_HOLD
  } wd_state_e;

endpackage

// File: rtl/bus_decode_if.sv
// 6502-side bus as seen by the responder: address, write data, write
// strobe and the interrupt-acknowledge return.
interface bus_decode_if;

  logic [15:0] s_addr;
  logic [7:0]  s_db_out;
  logic        s_WRITE_n;
  logic        s_INTACK_n;

  modport master (output s_addr, output s_db_out, output s_WRITE_n, input s_INTACK_n);
  modport slave  (input s_addr, input s_db_out, input s_WRITE_n, output s_INTACK_n);

endinterface

// File: rtl/mc_watchdog.sv
// Frame-counting watchdog: fires a fixed-width CPU reset request when too
// many frames pass without a kick.
module mc_watchdog
  import mc_pkg::*;
#(
  parameter int WDOG_FRAMES = 8,
  parameter int WDOG_PULSE  = 16
) (
  input  logic clk_10M,
  input  logic reset,
  input  logic frame_tick,
  input  logic kick,
  input  logic pause,
  output logic wdog_reset
);

  wd_state_e  state_q, state_d;
  logic [7:0] frameCnt_q, frameCnt_d;
  logic [7:0] pulseCnt_q, pulseCnt_d;

  always_ff @(posedge clk_10M) begin
    if (reset) begin
      state_q    <= WD_COUNT;
      frameCnt_q <= '0;
      pulseCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      frameCnt_q <= frameCnt_d;
      pulseCnt_q <= pulseCnt_d;
    end
  end

  // FIRE is the first high cycle, so HOLD leaves once the decremented count reaches 1.
  always_comb begin
    state_d    = state_q;
    frameCnt_d = frameCnt_q;
    pulseCnt_d = pulseCnt_q;
    wdog_reset = 1'b0;
    case (state_q)
      WD_COUNT: begin
        if (kick) begin
          frameCnt_d = '0;
        end else if (frame_tick && !pause) begin
          frameCnt_d = frameCnt_q + 8'd1;
          if (frameCnt_q == 8'(WDOG_FRAMES - 1)) state_d = WD_FIRE;
        end
      end
      WD_FIRE: begin
        wdog_reset = 1'b1;
        pulseCnt_d = 8'(WDOG_PULSE);
        if (WDOG_PULSE == 1) begin
          state_d    = WD_COUNT;
          frameCnt_d = '0;
        end else begin
          state_d = WD_HOLD;
        end
      end
      WD_HOLD: begin
        wdog_reset = 1'b1;
        pulseCnt_d = pulseCnt_q - 8'd1;
        if (pulseCnt_q <= 8'd2) begin
          state_d    = WD_COUNT;
          frameCnt_d = '0;
        end
      end
      default: state_d = WD_COUNT;
    endcase
  end

endmodule

// File: rtl/bus_decode.sv
// CPU-side bus responder: chip-select decode, write commits to the output
// latch and colour RAM, interrupt-acknowledge pulse and the watchdog.
module bus_decode
  import mc_pkg::*;
#(
  parameter int WDOG_FRAMES = 8,
  parameter int WDOG_PULSE  = 16,
  parameter int ACK_PULSE   = 2
) (
  input  logic        clk_10M,
  input  logic        reset,
  input  logic        pause,
  bus_decode_if.slave bus,
  input  logic [7:0]  vcnt,
  input  logic [2:0]  pix_idx,
  output logic        wdog_reset,
  output logic        ram_cs,
  output logic        pokey_cs,
  output logic        in0_oe,
  output logic        in1_oe,
  output logic        dip_oe,
  output logic        rom_cs,
  output logic [7:0]  out_latch,
  output logic [2:0]  pix_rgb
);

  logic [7:0] page;
  logic       wrN_q;
  logic       wrCommit;
  logic       frameTick;
  logic       kick;
  logic [7:0] vcntPrev_q;
  logic [7:0] outLatch_q;
  logic [2:0] colour_q [8];
  logic [2:0] pixRgb_q;
  logic [3:0] ackCnt_q, ackCnt_d;
  logic       unusedAddr;

  assign page       = bus.s_addr[15:8];
  assign unusedAddr = ^bus.s_addr[7:3];

  always_comb begin
    ram_cs   = (page <= RAM_HI);
    pokey_cs = (page >= POKEY_LO) && (page <= POKEY_HI);
    in0_oe   = (page == PG_IN0);
    in1_oe   = (page == PG_IN1);
    dip_oe   = (page == PG_DIP);
    rom_cs   = (page >= ROM_LO);
  end

  // One commit per strobe: only the first low cycle after a high one counts.
  assign wrCommit  = wrN_q & ~bus.s_WRITE_n;
  assign frameTick = (vcntPrev_q == 8'hFF) && (vcnt == 8'h00);
  assign kick      = wrCommit && (page == PG_WDOG);

  always_comb begin
    ackCnt_d = ackCnt_q;
    if (wrCommit && (page == PG_INTACK)) begin
      ackCnt_d = 4'(ACK_PULSE);
    end else if (ackCnt_q != 4'd0) begin
      ackCnt_d = ackCnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_10M) begin
    if (reset) begin
      wrN_q      <= 1'b1;
      vcntPrev_q <= '0;
      outLatch_q <= '0;
      pixRgb_q   <= '0;
      ackCnt_q   <= '0;
      for (int i = 0; i < 8; i++) colour_q[i] <= '0;
    end else begin
      wrN_q      <= bus.s_WRITE_n;
      vcntPrev_q <= vcnt;
      ackCnt_q   <= ackCnt_d;
      pixRgb_q   <= colour_q[pix_idx];
      if (wrCommit && (page == PG_OUTLATCH)) outLatch_q <= bus.s_db_out;
      if (wrCommit && (page == PG_COLOUR)) colour_q[bus.s_addr[2:0]] <= bus.s_db_out[3:1];
    end
  end

  assign bus.s_INTACK_n = (ackCnt_q == 4'd0);
  assign out_latch      = outLatch_q;
  assign pix_rgb        = pixRgb_q;

  mc_watchdog #(
    .WDOG_FRAMES (WDOG_FRAMES),
    .WDOG_PULSE  (WDOG_PULSE)
  ) u_watchdog (
    .clk_10M    (clk_10M),
    .reset      (reset),
    .frame_tick (frameTick),
    .kick       (kick),
    .pause      (pause),
    .wdog_reset (wdog_reset)
  );

endmodule

// File: tb/tb_bus_decode.sv
// Randomized bench for bus_decode, checked every cycle against a
// behavioural model of the bus map, ack pulse and watchdog.
module tb_bus_decode;

  localparam int WDOG_FRAMES = 8;
  localparam int WDOG_PULSE  = 16;
  localparam int ACK_PULSE   = 2;

  logic       clk_10M = 1'b0;
  logic       reset;
  logic       pause;
  logic [7:0] vcnt;
  logic [2:0] pix_idx;
  logic       wdog_reset;
  logic       ram_cs, pokey_cs, in0_oe, in1_oe, dip_oe, rom_cs;
  logic [7:0] out_latch;
  logic [2:0] pix_rgb;

  bus_decode_if bus ();

  bus_decode #(
    .WDOG_FRAMES (WDOG_FRAMES),
    .WDOG_PULSE  (WDOG_PULSE),
    .ACK_PULSE   (ACK_PULSE)
  ) dut (
    .clk_10M    (clk_10M),
    .reset      (reset),
    .pause      (pause),
    .bus        (bus),
    .vcnt       (vcnt),
    .pix_idx    (pix_idx),
    .wdog_reset (wdog_reset),
    .ram_cs     (ram_cs),
    .pokey_cs   (pokey_cs),
    .in0_oe     (in0_oe),
    .in1_oe     (in1_oe),
    .dip_oe     (dip_oe),
    .rom_cs     (rom_cs),
    .out_latch  (out_latch),
    .pix_rgb    (pix_rgb)
  );

  always #50 clk_10M = ~clk_10M;

  int nChecks = 0;
  int nPass   = 0;

  // Behavioural model state
  bit         mWrNPrev;
  logic [7:0] mOutLatch;
  logic [2:0] mColour [8];
  logic [2:0] mPix;
  int         mAckLeft;
  int         mFrames;
  int         mWdLeft;
  logic [7:0] mPrevVcnt;

  // Stimulus control
  int          wrLowLeft = 0;
  bit          rstReq    = 1'b1;
  bit          pauseReq  = 1'b0;
  bit          dirPending = 1'b0;
  logic [15:0] dirAddr;
  logic [7:0]  dirData;
  int          dirLen;
  int          nFires = 0;
  bit          prevWdog = 1'b0;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
  endtask

  task automatic modelReset();
    mWrNPrev  = 1'b1;
    mOutLatch = '0;
    for (int i = 0; i < 8; i++) mColour[i] = '0;
    mPix      = '0;
    mAckLeft  = 0;
    mFrames   = 0;
    mWdLeft   = 0;
    mPrevVcnt = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelStep();
    logic [7:0] pg;
    bit commit, tick;
    if (reset) begin
      modelReset();
      return;
    end
    pg     = bus.s_addr[15:8];
    commit = mWrNPrev && !bus.s_WRITE_n;
    tick   = (mPrevVcnt == 8'd255) && (vcnt == 8'd0);
    mPix   = mColour[pix_idx];
    if (mAckLeft > 0) mAckLeft--;
    if (commit && pg == 8'h48) mOutLatch = bus.s_db_out;
    if (commit && pg == 8'h4B) mColour[bus.s_addr[2:0]] = bus.s_db_out[3:1];
    if (commit && pg == 8'h4D) mAckLeft = ACK_PULSE;
    if (mWdLeft > 0) begin
      mWdLeft--;
      if (mWdLeft == 0) mFrames = 0;
    end else if (commit && pg == 8'h4C) begin
      mFrames = 0;
    end else if (tick && !pause) begin
      mFrames++;
      if (mFrames == WDOG_FRAMES) mWdLeft = WDOG_PULSE;
    end
    mWrNPrev  = bus.s_WRITE_n;
    mPrevVcnt = vcnt;
  endtask

  task automatic applyStimulus(input bit doWrite, input bit kickOk);
    logic [7:0] pg;
    int nextV;
    reset = rstReq;
    pause = pauseReq;
    if (wrLowLeft > 0) begin
      bus.s_WRITE_n = 1'b0;
      wrLowLeft--;
    end else begin
      bus.s_WRITE_n = 1'b1;
      if (dirPending) begin
        bus.s_addr   = dirAddr;
        bus.s_db_out = dirData;
        wrLowLeft    = dirLen;
        dirPending   = 1'b0;
      end else begin
        bus.s_addr   = 16'($urandom);
        bus.s_db_out = 8'($urandom);
        if (doWrite && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 5))
            0:       pg = 8'h48;
            1:       pg = 8'h4B;
            2, 3:    pg = 8'h4C;
            4:       pg = 8'h4D;
            default: pg = 8'($urandom);
          endcase
          if (!kickOk && pg == 8'h4C) pg = 8'h4D;
          bus.s_addr[15:8] = pg;
          wrLowLeft = int'($urandom_range(1, 5));
        end
      end
    end
    if (vcnt == 8'hFF) vcnt = 8'h00;
    else if (vcnt >= 8'd250) vcnt = vcnt + 8'd1;
    else begin
      nextV = int'(vcnt) + int'($urandom_range(1, 30));
      vcnt  = (nextV > 250) ? 8'd250 : 8'(nextV);
    end
    pix_idx = 3'($urandom);
  endtask

  task automatic compareAll();
    logic [7:0] pg;
    logic [5:0] expSel;
    pg     = bus.s_addr[15:8];
    expSel = {pg <= 8'h3F, (pg >= 8'h40) && (pg <= 8'h47), pg == 8'h48,
              pg == 8'h49, pg == 8'h4A, pg >= 8'h50};
    checkOutput("selects", 16'({ram_cs, pokey_cs, in0_oe, in1_oe, dip_oe, rom_cs}), 16'(expSel));
    checkOutput("s_INTACK_n", 16'(bus.s_INTACK_n), 16'(mAckLeft == 0));
    checkOutput("wdog_reset", 16'(wdog_reset), 16'(mWdLeft > 0));
    checkOutput("out_latch", 16'(out_latch), 16'(mOutLatch));
    checkOutput("pix_rgb", 16'(pix_rgb), 16'(mPix));
    if (wdog_reset === 1'b1 && !prevWdog) nFires++;
    prevWdog = (wdog_reset === 1'b1);
  endtask

  task automatic cycle(input bit doWrite, input bit kickOk);
    @(negedge clk_10M);
    applyStimulus(doWrite, kickOk);
    #5;
    compareAll();
    modelStep();
  endtask

  task automatic directedWrite(input logic [15:0] a, input logic [7:0] d, input int len);
    dirAddr    = a;
    dirData    = d;
    dirLen     = len;
    dirPending = 1'b1;
    repeat (len + 1) cycle(1'b0, 1'b0);
  endtask

  initial begin
    int guard;
    reset         = 1'b1;
    pause         = 1'b0;
    vcnt          = '0;
    pix_idx       = '0;
    bus.s_addr    = '0;
    bus.s_db_out  = '0;
    bus.s_WRITE_n = 1'b1;
    modelReset();
    repeat (2) @(posedge clk_10M);

    // Reset state, then idle for a few frames
    cycle(1'b0, 1'b0);
    rstReq = 1'b0;
    repeat (60) cycle(1'b0, 1'b0);

    // Directed writes: long strobe, colour mirrors, back-to-back acks
    directedWrite(16'h4800, 8'hA5, 5);
    directedWrite(16'h4B03, 8'h0E, 1);
    directedWrite(16'h4BF5, 8'h02, 2);
    directedWrite(16'h4D00, 8'h00, 1);
    directedWrite(16'h4D00, 8'h00, 1);
    repeat (10) cycle(1'b0, 1'b0);

    // Random traffic with kicks
    repeat (500) cycle(1'b1, 1'b1);

    // No kicks: watchdog must fire and restart
    nFires = 0;
    repeat (600) cycle(1'b1, 1'b0);
    checkOutput("wdogFired", 16'(nFires > 0), 16'd1);

    // Paused frame count, no kicks
    pauseReq = 1'b1;
    repeat (400) cycle(1'b1, 1'b0);
    pauseReq = 1'b0;

    // Reset in the middle of a watchdog pulse
    guard = 0;
    while (wdog_reset !== 1'b1 && guard < 3000) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    checkOutput("wdogRiseBound", 16'(guard < 3000), 16'd1);
    repeat (5) cycle(1'b1, 1'b0);
    rstReq = 1'b1;
    cycle(1'b0, 1'b0);
    rstReq = 1'b0;
    repeat (40) cycle(1'b1, 1'b1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
